// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 register window.
// Optional macro WINDOW_COORD_EN adds o_x/o_y giving the window centre coordinate.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int PIX_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic                          i_sof,
  input  logic [PIX_W-1:0]              i_pixel,
  output logic                          o_valid,
`ifdef WINDOW_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]  o_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_y,
`endif
  output logic [PIX_W-1:0]              PixelData_00,
  output logic [PIX_W-1:0]              PixelData_01,
  output logic [PIX_W-1:0]              PixelData_02,
  output logic [PIX_W-1:0]              PixelData_10,
  output logic [PIX_W-1:0]              PixelData_11,
  output logic [PIX_W-1:0]              PixelData_12,
  output logic [PIX_W-1:0]              PixelData_20,
  output logic [PIX_W-1:0]              PixelData_21,
  output logic [PIX_W-1:0]              PixelData_22
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [RW-1:0]    row_q, row_d, row_eff;
  logic             valid_q, valid_d;
  logic [PIX_W-1:0] lb0_q [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] new_col [3];

  // i_sof forces the current pixel to (0,0) before anything uses the position
  assign col_eff = i_sof ? '0 : col_q;
  assign row_eff = i_sof ? '0 : row_q;

  assign new_col[0] = lb1_q[col_eff];
  assign new_col[1] = lb0_q[col_eff];
  assign new_col[2] = i_pixel;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    if (i_valid) begin
      valid_d = (col_eff >= CW'(2)) && (row_eff >= RW'(2));
      if (col_eff == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(IMG_HEIGHT - 1)) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  // Read-before-write: lb1 takes the old lb0 entry as lb0 takes the new pixel
  always_ff @(posedge clk) begin
    if (i_valid) begin
      lb1_q[col_eff] <= lb0_q[col_eff];
      lb0_q[col_eff] <= i_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (i_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= new_col[r];
      end
    end
  end

`ifdef WINDOW_COORD_EN
  logic [CW-1:0] x_q;
  logic [RW-1:0] y_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (valid_d) begin
      x_q <= col_eff - CW'(1);
      y_q <= row_eff - RW'(1);
    end
  end

  assign o_x = x_q;
  assign o_y = y_q;
`endif

  assign o_valid      = valid_q;
  assign PixelData_00 = win_q[0][0];
  assign PixelData_01 = win_q[0][1];
  assign PixelData_02 = win_q[0][2];
  assign PixelData_10 = win_q[1][0];
  assign PixelData_11 = win_q[1][1];
  assign PixelData_12 = win_q[1][2];
  assign PixelData_20 = win_q[2][0];
  assign PixelData_21 = win_q[2][1];
  assign PixelData_22 = win_q[2][2];
endmodule
